// File: rtl/trigger_capture_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : trigger_capture_ctrl_pkg
//  Description : Shared definitions for the trigger/capture controller:
//                FSM state encoding, scope mode codes, geometry defaults.
//  Revision    : 1.0 - initial release
// ============================================================================
package trigger_capture_ctrl_pkg;

    // State encoding also drives the board LEDs, so the values are fixed.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_WAIT = 3'd2,
        ST_POST = 3'd3,
        ST_HOLD = 3'd4
    } state_t;

    // Mode codes; code 3 is decoded as normal.
    localparam logic [1:0] c_MODE_AUTO   = 2'd0;
    localparam logic [1:0] c_MODE_NORMAL = 2'd1;
    localparam logic [1:0] c_MODE_SINGLE = 2'd2;

    // Default frame geometry and auto-trigger timeout.
    localparam int c_DEPTH_DEFAULT   = 640;
    localparam int c_PRE_DEFAULT     = 320;
    localparam int c_AUTO_TO_DEFAULT = 4096;

    // Datapath widths.
    localparam int c_ADDR_W   = 10;
    localparam int c_SAMPLE_W = 12;

endpackage
`default_nettype wire

// File: rtl/trigger_capture_ctrl_trig_detect.sv
`default_nettype none
// ============================================================================
//  Module      : trig_detect
//  Description : Holds the previous accepted sample and compares it with the
//                current one against the trigger level for the chosen slope.
//  Revision    : 1.0 - initial release
//
//  Ports
//    CLOCK_50  in   1   clock
//    RESET_N   in   1   asynchronous active-low reset
//    clear     in   1   forget the previous sample (next sample cannot trigger)
//    update    in   1   store sample as the new previous sample
//    sample    in   12  current sample
//    level     in   12  trigger threshold
//    slope     in   1   0 = rising, 1 = falling
//    trig      out  1   current sample crosses the level (combinational)
// ============================================================================
module trig_detect
    import trigger_capture_ctrl_pkg::*;
(
    input  logic                  CLOCK_50,
    input  logic                  RESET_N,
    input  logic                  clear,
    input  logic                  update,
    input  logic [c_SAMPLE_W-1:0] sample,
    input  logic [c_SAMPLE_W-1:0] level,
    input  logic                  slope,
    output logic                  trig
);

    logic [c_SAMPLE_W-1:0] r_prev;
    logic                  r_prev_valid;
    logic                  w_rise;
    logic                  w_fall;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_prev       <= '0;
            r_prev_valid <= 1'b0;
        end else if (clear) begin
            r_prev_valid <= 1'b0;
        end else if (update) begin
            r_prev       <= sample;
            r_prev_valid <= 1'b1;
        end
    end

    assign w_rise = (r_prev < level) && (sample >= level);
    assign w_fall = (r_prev > level) && (sample <= level);
    assign trig   = r_prev_valid && (slope ? w_fall : w_rise);

endmodule
`default_nettype wire

// File: rtl/trigger_capture_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : trigger_capture_ctrl
//  Description : Oscilloscope capture controller. Decimates the ADC stream,
//                writes it into a circular sample RAM, detects the trigger,
//                and holds a frame of DEPTH words with PRE pre-trigger samples
//                for the display.
//  Revision    : 1.0 - initial release
//
//  Ports
//    CLOCK_50     in   1   clock
//    RESET_N      in   1   asynchronous active-low reset
//    sample_in    in   12  ADC code
//    sample_valid in   1   new conversion strobe
//    trig_level   in   12  trigger threshold
//    trig_slope   in   1   0 = rising, 1 = falling
//    mode         in   2   0 auto, 1 normal, 2 single, 3 normal
//    decim        in   3   keep one of every 2^decim samples
//    arm          in   1   restart capture
//    frame_ack    in   1   display finished reading the held frame
//    wr_en/wr_addr/wr_data  out  RAM port-A write
//    frame_base   out  10  address of oldest sample of held frame
//    frame_ready  out  1   a complete frame is held
//    auto_fired   out  1   held frame was closed by the auto timeout
//    state        out  3   FSM state for the LEDs
// ============================================================================
module trigger_capture_ctrl
    import trigger_capture_ctrl_pkg::*;
#(
    parameter int DEPTH   = c_DEPTH_DEFAULT,
    parameter int PRE     = c_PRE_DEFAULT,
    parameter int AUTO_TO = c_AUTO_TO_DEFAULT
) (
    input  logic                  CLOCK_50,
    input  logic                  RESET_N,
    input  logic [c_SAMPLE_W-1:0] sample_in,
    input  logic                  sample_valid,
    input  logic [c_SAMPLE_W-1:0] trig_level,
    input  logic                  trig_slope,
    input  logic [1:0]            mode,
    input  logic [2:0]            decim,
    input  logic                  arm,
    input  logic                  frame_ack,
    output logic                  wr_en,
    output logic [c_ADDR_W-1:0]   wr_addr,
    output logic [c_SAMPLE_W-1:0] wr_data,
    output logic [c_ADDR_W-1:0]   frame_base,
    output logic                  frame_ready,
    output logic                  auto_fired,
    output logic [2:0]            state
);

    localparam int c_AW     = c_ADDR_W;
    localparam int c_POST_N = DEPTH - PRE - 1;
    localparam int c_ACW    = $clog2(AUTO_TO + 1);

    localparam logic [c_AW-1:0]  c_PTR_LAST  = c_AW'(DEPTH - 1);
    localparam logic [c_AW-1:0]  c_PRE_LAST  = c_AW'(PRE - 1);
    localparam logic [c_AW-1:0]  c_POST_LAST = c_AW'(c_POST_N - 1);
    localparam logic [c_AW-1:0]  c_PRE_OFS   = c_AW'(PRE);
    localparam logic [c_AW-1:0]  c_WRAP_OFS  = c_AW'(DEPTH - PRE);
    localparam logic [c_ACW-1:0] c_AUTO_MAX  = c_ACW'(AUTO_TO);

    state_t                r_state;
    logic [6:0]            r_dec_cnt;
    logic [c_AW-1:0]       r_wr_ptr;
    logic [c_AW-1:0]       r_pre_cnt;
    logic [c_AW-1:0]       r_post_cnt;
    logic [c_ACW-1:0]      r_auto_cnt;
    logic                  r_wr_en;
    logic [c_AW-1:0]       r_wr_addr;
    logic [c_SAMPLE_W-1:0] r_wr_data;
    logic [c_AW-1:0]       r_frame_base;
    logic                  r_frame_ready;
    logic                  r_auto_fired;

    logic [6:0]            w_dec_lim;
    logic                  w_accept;
    logic                  w_capturing;
    logic                  w_write;
    logic                  w_is_auto;
    logic                  w_is_single;
    logic                  w_leave_hold;
    logic                  w_trig;
    logic                  w_trig_clear;
    logic                  w_force;
    logic [c_AW-1:0]       w_ptr_next;
    logic [c_AW-1:0]       w_base;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    assign w_is_auto    = (mode == c_MODE_AUTO);
    assign w_is_single  = (mode == c_MODE_SINGLE);
    assign w_dec_lim    = 7'((8'd1 << decim) - 8'd1);
    assign w_accept     = sample_valid && (r_dec_cnt == 7'd0);
    assign w_capturing  = (r_state == ST_PRE) || (r_state == ST_WAIT) || (r_state == ST_POST);
    assign w_write      = w_capturing && w_accept && !arm;
    assign w_leave_hold = (r_state == ST_HOLD) && frame_ack && !w_is_single;
    assign w_trig_clear = arm || (r_state == ST_IDLE);
    assign w_force      = w_is_auto && (r_auto_cnt == c_AUTO_MAX);
    assign w_ptr_next   = (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + c_AW'(1);
    // Oldest sample of the frame sits PRE words behind the trigger sample.
    assign w_base       = (r_wr_ptr >= c_PRE_OFS) ? (r_wr_ptr - c_PRE_OFS)
                                                  : (r_wr_ptr + c_WRAP_OFS);

    trig_detect u_trig_detect (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .clear    (w_trig_clear),
        .update   (w_write),
        .sample   (sample_in),
        .level    (trig_level),
        .slope    (trig_slope),
        .trig     (w_trig)
    );

    // ------------------------------------------------------------------
    // Decimation counter: runs in every state, restarts with each frame
    // so the first valid sample of a capture is always kept.
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_dec_cnt <= '0;
        end else if (arm || w_leave_hold) begin
            r_dec_cnt <= '0;
        end else if (sample_valid) begin
            r_dec_cnt <= (r_dec_cnt >= w_dec_lim) ? 7'd0 : r_dec_cnt + 7'd1;
        end
    end

    // ------------------------------------------------------------------
    // Capture FSM, write port and frame registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state       <= ST_IDLE;
            r_wr_ptr      <= '0;
            r_pre_cnt     <= '0;
            r_post_cnt    <= '0;
            r_auto_cnt    <= '0;
            r_wr_en       <= 1'b0;
            r_wr_addr     <= '0;
            r_wr_data     <= '0;
            r_frame_base  <= '0;
            r_frame_ready <= 1'b0;
            r_auto_fired  <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;

            if (w_write) begin
                r_wr_en   <= 1'b1;
                r_wr_addr <= r_wr_ptr;
                r_wr_data <= sample_in;
                r_wr_ptr  <= w_ptr_next;
            end

            if (arm) begin
                // Arm behaves like IDLE from any state and wins over
                // a simultaneous trigger or frame_ack.
                r_state       <= ST_PRE;
                r_pre_cnt     <= '0;
                r_post_cnt    <= '0;
                r_auto_cnt    <= '0;
                r_frame_ready <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state       <= ST_PRE;
                        r_pre_cnt     <= '0;
                        r_frame_ready <= 1'b0;
                    end

                    ST_PRE: begin
                        if (w_accept) begin
                            if (r_pre_cnt == c_PRE_LAST) begin
                                r_state    <= ST_WAIT;
                                r_auto_cnt <= '0;
                            end else begin
                                r_pre_cnt <= r_pre_cnt + c_AW'(1);
                            end
                        end
                    end

                    ST_WAIT: begin
                        if (w_accept) begin
                            if (w_trig || w_force) begin
                                r_frame_base <= w_base;
                                r_auto_fired <= !w_trig;
                                r_post_cnt   <= '0;
                                if (c_POST_N == 0) begin
                                    r_state       <= ST_HOLD;
                                    r_frame_ready <= 1'b1;
                                end else begin
                                    r_state <= ST_POST;
                                end
                            end else if (r_auto_cnt != c_AUTO_MAX) begin
                                r_auto_cnt <= r_auto_cnt + c_ACW'(1);
                            end
                        end
                    end

                    ST_POST: begin
                        if (w_accept) begin
                            if (r_post_cnt == c_POST_LAST) begin
                                r_state       <= ST_HOLD;
                                r_frame_ready <= 1'b1;
                            end else begin
                                r_post_cnt <= r_post_cnt + c_AW'(1);
                            end
                        end
                    end

                    ST_HOLD: begin
                        if (w_leave_hold) begin
                            r_state       <= ST_PRE;
                            r_pre_cnt     <= '0;
                            r_frame_ready <= 1'b0;
                        end
                    end

                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign wr_en       = r_wr_en;
    assign wr_addr     = r_wr_addr;
    assign wr_data     = r_wr_data;
    assign frame_base  = r_frame_base;
    assign frame_ready = r_frame_ready;
    assign auto_fired  = r_auto_fired;
    assign state       = r_state;

endmodule
`default_nettype wire

// File: doc/trigger_capture_ctrl.md
TRIGGER_CAPTURE_CTRL -- requirements
Module: trigger_capture_ctrl

Interface
REQ-001 Parameter DEPTH, default 640: sample-RAM frame length in words; the address range is 0..DEPTH-1.
REQ-002 Parameter PRE, default 320: number of pre-trigger samples kept in each frame; legal range 1..DEPTH-1.
REQ-003 Parameter AUTO_TO, default 4096: number of accepted samples waited in auto mode before a forced trigger.
REQ-004 CLOCK_50  in  1  single clock; every flop is rising-edge.
REQ-005 RESET_N  in  1  asynchronous, active-low reset.
REQ-006 sample_in  in  12  current ADC CH0 code, unsigned.
REQ-007 sample_valid  in  1  one-cycle pulse when sample_in holds a new conversion.
REQ-008 trig_level  in  12  trigger threshold, unsigned.
REQ-009 trig_slope  in  1  0 = rising edge, 1 = falling edge.
REQ-010 mode  in  2  0 = auto, 1 = normal, 2 = single; 3 is treated as normal.
REQ-011 decim  in  3  keep one accepted sample in every 2^decim valid samples.
REQ-012 arm  in  1  one-cycle pulse that restarts capture.
REQ-013 frame_ack  in  1  one-cycle pulse from the display at the end of the frame it has read.
REQ-014 wr_en  out  1  RAM port-A write strobe.
REQ-015 wr_addr  out  10  RAM port-A write address.
REQ-016 wr_data  out  12  RAM port-A write data.
REQ-017 frame_base  out  10  RAM address of the oldest sample in the held frame; the display reads from frame_base plus pixel_x, modulo DEPTH.
REQ-018 frame_ready  out  1  high while a complete frame is held.
REQ-019 auto_fired  out  1  high when the held frame was closed by the auto timeout rather than a real trigger.
REQ-020 state  out  3  state encoding, for the LEDs.

Function
REQ-021 The block SHALL implement five states: IDLE, PRE, WAIT, POST and HOLD.
REQ-022 The block SHALL increment a decimation counter on each sample_valid, wrapping at 2^decim-1; a sample SHALL be accepted only when sample_valid=1 and the counter is 0, and the counter SHALL clear on arm and on leaving HOLD.
REQ-023 Every accepted sample in PRE, WAIT or POST SHALL produce wr_en=1 exactly one cycle later, with wr_data equal to that sample and wr_addr equal to the current write pointer.
REQ-024 The write pointer SHALL advance after each write and SHALL wrap from DEPTH-1 to 0.
REQ-025 wr_en SHALL be 0 in IDLE and HOLD.
REQ-026 IDLE SHALL go to PRE on the cycle after reset release, or on arm; it SHALL clear the pre-trigger count and frame_ready.
REQ-027 PRE SHALL go to WAIT after PRE accepted samples.
REQ-028 A trigger SHALL be detected on an accepted sample s with previous accepted sample p when:
  - rising: p < trig_level and s >= trig_level;
  - falling: p > trig_level and s <= trig_level.
REQ-029 p SHALL update on every accepted sample in PRE, WAIT and POST; the first sample after IDLE SHALL NOT trigger.
REQ-030 On a trigger in WAIT, the block SHALL latch frame_base = (trigger sample address - PRE) mod DEPTH, write the trigger sample, and go to POST.
REQ-031 In WAIT with mode=auto, after AUTO_TO accepted samples with no trigger, the block SHALL force a trigger on the next accepted sample and set auto_fired; a real trigger SHALL clear auto_fired.
REQ-032 POST SHALL go to HOLD after DEPTH-PRE-1 further writes, so the frame totals DEPTH writes after the trigger sample.
REQ-033 HOLD SHALL assert frame_ready and leave frame_base stable.
REQ-034 HOLD exit rules:
  - auto or normal: frame_ack goes to PRE;
  - single: frame_ack is ignored, and only arm goes to PRE.
REQ-035 arm in any state SHALL force IDLE behaviour on that cycle (entering PRE next); it SHALL dominate a simultaneous trigger or frame_ack.
REQ-036 Changes to mode, decim, trig_level or trig_slope SHALL take effect on the next accepted sample, with no state change.
REQ-037 frame_ack outside HOLD SHALL be ignored.

Reset
REQ-038 While RESET_N=0, the block SHALL hold state=IDLE, wr_en=0, wr_addr=0, wr_data=0, frame_base=0, frame_ready=0, auto_fired=0, and all counters at 0.
REQ-039 Assertion mid-frame SHALL discard the frame; after release, capture SHALL restart in PRE.

Structure
REQ-040 A shared package SHALL hold the state encoding, the mode codes and the DEPTH/PRE/AUTO_TO defaults.
REQ-041 One sub-module, trig_detect, SHALL hold p and the slope compare; the rest of the logic is a single FSM plus counters.

Verification
REQ-042 Rising-edge trigger: DEPTH=640, PRE=320, decim=0, mode=normal, level=2048, ramp 0..4095 step 16 per valid sample -> trigger on the sample crossing 2048, exactly 640 writes total, frame_ready=1, frame_base = trigger address - 320 mod 640.
REQ-043 Auto timeout: constant input 1000, level=3000, mode=auto, AUTO_TO=64 -> HOLD reached after 320+64+320 accepted samples, auto_fired=1.
REQ-044 Single mode: single, one trigger, then frame_ack pulses -> HOLD persists; arm -> PRE on the next cycle, frame_ready=0.
REQ-045 Decimation: decim=3, 80 valid pulses in PRE -> exactly 10 writes, addresses consecutive.
REQ-046 Wrap and reset: trigger at write address 100 -> frame_base=420; RESET_N pulsed low during POST -> all outputs 0 immediately, PRE after release.
